// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_IN-lane adder tree with valid tagging; stage 0 registers lanes, then LOG2N adder levels.
// Define ADDER_TREE_ACC_EN to add a saturating running accumulator after the tree.
module adder_tree_pipe #(
    parameter int WIDTH  = 12,
    parameter int NUM_IN = 8,
    parameter int LOG2N  = 3,
    parameter int SIGNED = 1,
    parameter int ACC_W  = 20,
    localparam int SUM_W = WIDTH + LOG2N,
`ifdef ADDER_TREE_ACC_EN
    localparam int OUT_W = ACC_W
`else
    localparam int OUT_W = SUM_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    input  logic [NUM_IN*WIDTH-1:0] i_in_data,
    input  logic                    i_acc_clr,
    output logic                    o_out_valid,
    output logic [OUT_W-1:0]        o_out_sum
);

    localparam int NODES = 2 * NUM_IN - 1;

    generate
        if ((1 << LOG2N) != NUM_IN) begin : g_bad_log2n
            $error("adder_tree_pipe: LOG2N does not match NUM_IN");
        end
        if (ACC_W < SUM_W) begin : g_bad_acc_w
            $error("adder_tree_pipe: ACC_W must be at least WIDTH+LOG2N");
        end
    endgenerate

    logic [SUM_W-1:0] w_lane_ext [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
            logic [WIDTH-1:0] w_lane;
            assign w_lane = i_in_data[gi*WIDTH +: WIDTH];
            assign w_lane_ext[gi] = (SIGNED != 0) ? {{LOG2N{w_lane[WIDTH-1]}}, w_lane}
                                                  : {{LOG2N{1'b0}}, w_lane};
        end
    endgenerate

    // Heap layout: node 0 is the root, children of n are 2n+1 / 2n+2, leaves occupy
    // NUM_IN-1 .. 2*NUM_IN-2, so every tree level is exactly one register deep.
    logic [SUM_W-1:0] r_node [NODES];
    logic [LOG2N:0]   r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                r_node[n] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[LOG2N-1:0], i_in_valid};
            for (int k = 0; k < NUM_IN; k++) begin
                r_node[NUM_IN-1+k] <= w_lane_ext[k];
            end
            for (int n = 0; n < NUM_IN - 1; n++) begin
                r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
            end
        end
    end

    logic [SUM_W-1:0] w_tree_sum;
    logic             w_tree_valid;

    assign w_tree_sum   = r_node[0];
    assign w_tree_valid = r_valid[LOG2N];

`ifdef ADDER_TREE_ACC_EN
    logic [ACC_W:0]   w_tree_x;
    logic [ACC_W:0]   w_acc_x;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_valid;

    // One guard bit is enough: both addends already fit in ACC_W bits.
    assign w_tree_x = (SIGNED != 0) ? {{(ACC_W+1-SUM_W){w_tree_sum[SUM_W-1]}}, w_tree_sum}
                                    : {{(ACC_W+1-SUM_W){1'b0}}, w_tree_sum};
    assign w_acc_x  = (SIGNED != 0) ? {r_acc[ACC_W-1], r_acc} : {1'b0, r_acc};
    assign w_add    = w_acc_x + w_tree_x;

    always_comb begin
        w_acc_next = w_add[ACC_W-1:0];
        if (SIGNED != 0) begin
            if (w_add[ACC_W] != w_add[ACC_W-1]) begin
                w_acc_next = w_add[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (w_add[ACC_W]) begin
            w_acc_next = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= w_tree_valid;
            if (w_tree_valid) begin
                r_acc <= i_acc_clr ? w_tree_x[ACC_W-1:0] : w_acc_next;
            end else if (i_acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign o_out_valid = r_acc_valid;
    assign o_out_sum   = r_acc;
`else
    logic w_unused_acc_clr;

    assign w_unused_acc_clr = i_acc_clr;
    assign o_out_valid      = w_tree_valid;
    assign o_out_sum        = w_tree_sum;
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: a signed and an unsigned instance share the same stimulus.
// Expected sums come from an integer lane model; with ADDER_TREE_ACC_EN a saturating accumulator model.
module tb_adder_tree_pipe;

    localparam int WIDTH  = 12;
    localparam int NUM_IN = 8;
    localparam int LOG2N  = 3;
    localparam int ACC_W  = 16;
    localparam int SUM_W  = WIDTH + LOG2N;
    localparam int DW     = NUM_IN * WIDTH;
`ifdef ADDER_TREE_ACC_EN
    localparam int OUT_W  = ACC_W;
    localparam int LAT    = LOG2N + 2;
`else
    localparam int OUT_W  = SUM_W;
    localparam int LAT    = LOG2N + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_in_valid;
    logic [DW-1:0]    i_in_data;
    logic             i_acc_clr;
    logic             o_valid_s;
    logic [OUT_W-1:0] o_sum_s;
    logic             o_valid_u;
    logic [OUT_W-1:0] o_sum_u;

    adder_tree_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .LOG2N(LOG2N), .SIGNED(1), .ACC_W(ACC_W)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .i_acc_clr(i_acc_clr), .o_out_valid(o_valid_s), .o_out_sum(o_sum_s));

    adder_tree_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .LOG2N(LOG2N), .SIGNED(0), .ACC_W(ACC_W)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .i_acc_clr(i_acc_clr), .o_out_valid(o_valid_u), .o_out_sum(o_sum_u));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        longint sum_s;
        longint sum_u;
        bit     clr;
    } exp_t;

    exp_t   sb[$];
    bit     clr_line [1024];
    int     checks   = 0;
    int     failures = 0;
    longint acc_s    = 0;
    longint acc_u    = 0;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model(input logic [DW-1:0] d, output longint ss, output longint su);
        logic [WIDTH-1:0] l;
        ss = 0;
        su = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            l = d[k*WIDTH +: WIDTH];
            su += longint'(l);
            ss += l[WIDTH-1] ? longint'(l) - (longint'(1) << WIDTH) : longint'(l);
        end
    endfunction

    function automatic longint sat_s(input longint x);
        longint hi = (longint'(1) << (ACC_W-1)) - 1;
        longint lo = -(longint'(1) << (ACC_W-1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic longint sat_u(input longint x);
        longint hi = (longint'(1) << ACC_W) - 1;
        return (x > hi) ? hi : ((x < 0) ? 0 : x);
    endfunction

    function automatic logic [DW-1:0] lanes2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit halves);
        logic [DW-1:0] d;
        for (int k = 0; k < NUM_IN; k++) begin
            if (halves) d[k*WIDTH +: WIDTH] = (k < NUM_IN/2) ? a : b;
            else        d[k*WIDTH +: WIDTH] = k[0] ? b : a;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return d;
    endfunction

    task automatic monitor();
        logic             ev;
        exp_t             e;
        logic [OUT_W-1:0] xs;
        logic [OUT_W-1:0] xu;
        ev = (sb.size() > 0) && (sb[0].due == cyc);
        check("valid_s", OUT_W'(o_valid_s), OUT_W'(ev));
        check("valid_u", OUT_W'(o_valid_u), OUT_W'(ev));
        if (ev) begin
            e = sb.pop_front();
`ifdef ADDER_TREE_ACC_EN
            acc_s = e.clr ? e.sum_s : sat_s(acc_s + e.sum_s);
            acc_u = e.clr ? e.sum_u : sat_u(acc_u + e.sum_u);
            xs = OUT_W'(acc_s);
            xu = OUT_W'(acc_u);
`else
            xs = OUT_W'(e.sum_s);
            xu = OUT_W'(e.sum_u);
`endif
            check("sum_s", o_sum_s, xs);
            check("sum_u", o_sum_u, xu);
            $display("cyc=%0d out sum_s=%h sum_u=%h (expected %h / %h)", cyc, o_sum_s, o_sum_u, xs, xu);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit clr);
        longint ss;
        longint su;
        exp_t   e;
        @(posedge clk);
        #1;
        i_acc_clr  = clr_line[cyc % 1024];
        i_in_valid = v;
        i_in_data  = d;
        if (v) begin
            model(d, ss, su);
            if (clr) clr_line[(cyc + LOG2N + 1) % 1024] = 1'b1;
            e.due   = cyc + LAT;
            e.sum_s = ss;
            e.sum_u = su;
            e.clr   = clr;
            sb.push_back(e);
            $display("cyc=%0d in  data=%h clr=%0d", cyc, d, clr);
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rnd_data(), 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_acc_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_s", OUT_W'(o_valid_s), '0);
        check("rst_sum_s",   o_sum_s,           '0);
        check("rst_valid_u", OUT_W'(o_valid_u), '0);
        check("rst_sum_u",   o_sum_u,           '0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back full-scale patterns
        step(1'b1, lanes2(12'hFFF, 12'hFFF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h800, 12'h800, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h001, 12'h001, 1'b0), 1'b0);
        // Mixed lanes that cancel or nearly cancel
        step(1'b1, lanes2(12'h001, 12'hFFF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'hAAA, 12'h555, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h7FF, 12'h801, 1'b1), 1'b0);
        idle(6);

        // Bubble pattern 1,0,1,1,0
        step(1'b1, rnd_data(), 1'b0);
        step(1'b0, rnd_data(), 1'b0);
        step(1'b1, rnd_data(), 1'b0);
        step(1'b1, rnd_data(), 1'b0);
        step(1'b0, rnd_data(), 1'b0);
        idle(6);

        // Reset with three samples in flight
        step(1'b1, lanes2(12'h123, 12'h456, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h001, 12'h002, 1'b1), 1'b0);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        #1;
        check("inflight_rst_valid_s", OUT_W'(o_valid_s), '0);
        check("inflight_rst_sum_s",   o_sum_s,           '0);
        check("inflight_rst_valid_u", OUT_W'(o_valid_u), '0);
        check("inflight_rst_sum_u",   o_sum_u,           '0);
        sb.delete();
        acc_s = 0;
        acc_u = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        monitor();
        idle(8);

        // Accumulation sequence: clear on the first sample, then saturate
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b1);
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h7FF, 12'h7FF, 1'b0), 1'b0);
        step(1'b1, lanes2(12'h800, 12'h800, 1'b0), 1'b0);
        idle(8);

`ifdef ADDER_TREE_ACC_EN
        // Clear with no valid sample empties the accumulator
        clr_line[(cyc + 1) % 1024] = 1'b1;
        idle(3);
        acc_s = 0;
        acc_u = 0;
        check("clr_idle_s", o_sum_s, '0);
        check("clr_idle_u", o_sum_u, '0);
        step(1'b1, lanes2(12'hFFF, 12'h003, 1'b0), 1'b0);
        idle(6);
`endif

        // Random traffic with random bubbles
        for (int i = 0; i < 24; i++) step(1'($urandom), rnd_data(), ($urandom_range(0, 7) == 0));

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        check("drain", OUT_W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
